// File: rtl/call_ret_seq.sv
// Program-counter sequencer for a 4-entry return-address stack.
// Handles CALL/RET/STEP, tracks stack depth, and flags overflow/underflow as sticky errors.
module call_ret_seq #(
    parameter int          AW       = 20,
    parameter int          DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int          CW       = $clog2(DEPTH + 1)
) (
    input  logic          CLK2,
    input  logic          RST_N,
    input  logic          STEP,
    input  logic          CALL,
    input  logic          RET,
    input  logic [AW-1:0] TARGET,
    output logic [AW-1:0] PC,
    output logic          BUSY,
    output logic          ENA,
    output logic [AW-1:0] DI,
    output logic          RTS,
    input  logic [AW-1:0] DO,
    output logic [CW-1:0] DEPTH_CNT,
    output logic          OVF,
    output logic          UNF
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH,
        S_POP
    } state_t;

    localparam logic [CW-1:0] DEPTH_FULL = CW'(DEPTH);

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] di_q;
    logic [CW-1:0] depth_q;
    logic          busy_q;
    logic          ena_q;
    logic          rts_q;
    logic          ovf_q;
    logic          unf_q;

    logic [AW-1:0] pc_inc;

    // Natural AW-bit wrap gives 2^AW-1 -> 0.
    assign pc_inc = pc_q + AW'(1);

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // which is what lets DI capture the old PC while PC takes TARGET.
    always_ff @(posedge CLK2 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            di_q    <= '0;
            depth_q <= '0;
            busy_q  <= 1'b0;
            ena_q   <= 1'b0;
            rts_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (CALL) begin
                        if (depth_q != DEPTH_FULL) begin
                            ena_q   <= 1'b1;
                            di_q    <= pc_inc;
                            pc_q    <= TARGET;
                            depth_q <= depth_q + CW'(1);
                            busy_q  <= 1'b1;
                            state_q <= S_PUSH;
                        end else begin
                            ovf_q <= 1'b1;
                            pc_q  <= pc_inc;
                        end
                    end else if (RET) begin
                        // DO is the settled top here because PUSH/POP always return through IDLE.
                        if (depth_q != '0) begin
                            pc_q    <= DO;
                            rts_q   <= 1'b1;
                            depth_q <= depth_q - CW'(1);
                            busy_q  <= 1'b1;
                            state_q <= S_POP;
                        end else begin
                            unf_q <= 1'b1;
                            pc_q  <= pc_inc;
                        end
                    end else if (STEP) begin
                        pc_q <= pc_inc;
                    end
                end
                S_PUSH, S_POP: begin
                    ena_q   <= 1'b0;
                    rts_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ena_q   <= 1'b0;
                    rts_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign PC        = pc_q;
    assign BUSY      = busy_q;
    assign ENA       = ena_q;
    assign DI        = di_q;
    assign RTS       = rts_q;
    assign DEPTH_CNT = depth_q;
    assign OVF       = ovf_q;
    assign UNF       = unf_q;

endmodule

// File: tb/tb_call_ret_seq.sv
// Scoreboard bench for call_ret_seq: directed commands push expected post-edge snapshots,
// a monitor pops and compares once per cycle on the falling edge.
module tb_call_ret_seq;

    localparam int AW = 20;
    localparam int CW = 3;

    logic          CLK2 = 1'b0;
    logic          RST_N;
    logic          STEP, CALL, RET;
    logic [AW-1:0] TARGET;
    logic [AW-1:0] PC, DI, DO;
    logic          BUSY, ENA, RTS, OVF, UNF;
    logic [CW-1:0] DEPTH_CNT;

    call_ret_seq #(.AW(AW), .DEPTH(4), .RESET_PC(20'h00100)) dut (
        .CLK2(CLK2), .RST_N(RST_N), .STEP(STEP), .CALL(CALL), .RET(RET),
        .TARGET(TARGET), .PC(PC), .BUSY(BUSY), .ENA(ENA), .DI(DI), .RTS(RTS),
        .DO(DO), .DEPTH_CNT(DEPTH_CNT), .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK2 = ~CLK2;

    // Return-address stack environment: no reset, updates on the edge that samples ENA/RTS.
    logic [AW-1:0] stk [4];
    int sp = 0;
    assign DO = (sp > 0) ? stk[sp-1] : '0;
    always @(posedge CLK2) begin
        if (ENA && sp < 4) begin
            stk[sp] <= DI;
            sp      <= sp + 1;
        end else if (RTS && sp > 0) begin
            sp <= sp - 1;
        end
    end

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          busy;
        logic          ena;
        logic          rts;
        logic [AW-1:0] di;
        logic [CW-1:0] depth;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   n_id = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic [AW-1:0] pc, input logic busy, input logic ena,
                                input logic rts, input logic [AW-1:0] di,
                                input logic [CW-1:0] depth, input logic ovf, input logic unf);
        exp_t e;
        e.pc = pc; e.busy = busy; e.ena = ena; e.rts = rts;
        e.di = di; e.depth = depth; e.ovf = ovf; e.unf = unf;
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        exp_q.push_back(e);
        id_q.push_back(n_id);
        n_id++;
    endtask

    // Drive one command across one rising edge, then queue the expected state after that edge.
    task automatic cyc(input logic s, input logic c, input logic r,
                       input logic [AW-1:0] tgt, input exp_t e);
        STEP = s; CALL = c; RET = r; TARGET = tgt;
        @(posedge CLK2);
        #1;
        push_exp(e);
    endtask

    // Monitor: the DUT presents its registered outputs every cycle.
    initial begin
        forever begin
            @(negedge CLK2);
            if (exp_q.size() > 0) begin
                exp_t e;
                exp_t a;
                int   id;
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                a  = mk(PC, BUSY, ENA, RTS, DI, DEPTH_CNT, OVF, UNF);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL step%0d: got pc=%h busy=%b ena=%b rts=%b di=%h depth=%0d ovf=%b unf=%b | want pc=%h busy=%b ena=%b rts=%b di=%h depth=%0d ovf=%b unf=%b",
                             id, a.pc, a.busy, a.ena, a.rts, a.di, a.depth, a.ovf, a.unf,
                             e.pc, e.busy, e.ena, e.rts, e.di, e.depth, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        RST_N = 1'b0; STEP = 1'b0; CALL = 1'b0; RET = 1'b0; TARGET = '0;
        #1;
        push_exp(mk(20'h00100, 0, 0, 0, 20'h0, 0, 0, 0));
        @(negedge CLK2);
        #2;
        RST_N = 1'b1;

        // Reach PC=0x010 with one frame below, then CALL/RET pair.
        cyc(0, 1, 0, 20'h0000F, mk(20'h0000F, 1, 1, 0, 20'h00101, 1, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h0000F, 0, 0, 0, 20'h00101, 1, 0, 0));
        cyc(1, 0, 0, 20'h0,     mk(20'h00010, 0, 0, 0, 20'h00101, 1, 0, 0));
        cyc(0, 1, 0, 20'h00400, mk(20'h00400, 1, 1, 0, 20'h00011, 2, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00400, 0, 0, 0, 20'h00011, 2, 0, 0));
        cyc(0, 0, 1, 20'h0,     mk(20'h00011, 1, 0, 1, 20'h00011, 1, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00011, 0, 0, 0, 20'h00011, 1, 0, 0));
        cyc(0, 0, 1, 20'h0,     mk(20'h00101, 1, 0, 1, 20'h00011, 0, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00101, 0, 0, 0, 20'h00011, 0, 0, 0));

        // Four nested CALLs, a refused fifth, then four LIFO RETs.
        cyc(0, 1, 0, 20'h00200, mk(20'h00200, 1, 1, 0, 20'h00102, 1, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00200, 0, 0, 0, 20'h00102, 1, 0, 0));
        cyc(0, 1, 0, 20'h00300, mk(20'h00300, 1, 1, 0, 20'h00201, 2, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00300, 0, 0, 0, 20'h00201, 2, 0, 0));
        cyc(0, 1, 0, 20'h00500, mk(20'h00500, 1, 1, 0, 20'h00301, 3, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00500, 0, 0, 0, 20'h00301, 3, 0, 0));
        cyc(0, 1, 0, 20'h00600, mk(20'h00600, 1, 1, 0, 20'h00501, 4, 0, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00600, 0, 0, 0, 20'h00501, 4, 0, 0));
        cyc(0, 1, 0, 20'h00700, mk(20'h00601, 0, 0, 0, 20'h00501, 4, 1, 0));
        cyc(0, 0, 1, 20'h0,     mk(20'h00501, 1, 0, 1, 20'h00501, 3, 1, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00501, 0, 0, 0, 20'h00501, 3, 1, 0));
        cyc(0, 0, 1, 20'h0,     mk(20'h00301, 1, 0, 1, 20'h00501, 2, 1, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00301, 0, 0, 0, 20'h00501, 2, 1, 0));
        cyc(0, 0, 1, 20'h0,     mk(20'h00201, 1, 0, 1, 20'h00501, 1, 1, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00201, 0, 0, 0, 20'h00501, 1, 1, 0));
        cyc(0, 0, 1, 20'h0,     mk(20'h00102, 1, 0, 1, 20'h00501, 0, 1, 0));
        cyc(0, 0, 0, 20'h0,     mk(20'h00102, 0, 0, 0, 20'h00501, 0, 1, 0));

        // Underflow, then PC wrap at the top of the address space.
        cyc(0, 0, 1, 20'h0,     mk(20'h00103, 0, 0, 0, 20'h00501, 0, 1, 1));
        cyc(0, 1, 0, 20'hFFFFE, mk(20'hFFFFE, 1, 1, 0, 20'h00104, 1, 1, 1));
        cyc(0, 0, 0, 20'h0,     mk(20'hFFFFE, 0, 0, 0, 20'h00104, 1, 1, 1));
        cyc(1, 0, 0, 20'h0,     mk(20'hFFFFF, 0, 0, 0, 20'h00104, 1, 1, 1));
        cyc(1, 0, 0, 20'h0,     mk(20'h00000, 0, 0, 0, 20'h00104, 1, 1, 1));
        cyc(0, 0, 1, 20'h0,     mk(20'h00104, 1, 0, 1, 20'h00104, 0, 1, 1));
        cyc(0, 0, 0, 20'h0,     mk(20'h00104, 0, 0, 0, 20'h00104, 0, 1, 1));

        // Priority among simultaneous commands; commands while BUSY are ignored.
        cyc(1, 1, 1, 20'h00800, mk(20'h00800, 1, 1, 0, 20'h00105, 1, 1, 1));
        cyc(1, 1, 1, 20'h00900, mk(20'h00800, 0, 0, 0, 20'h00105, 1, 1, 1));
        cyc(1, 0, 1, 20'h0,     mk(20'h00105, 1, 0, 1, 20'h00105, 0, 1, 1));
        cyc(1, 1, 0, 20'h00A00, mk(20'h00105, 0, 0, 0, 20'h00105, 0, 1, 1));
        cyc(1, 0, 1, 20'h0,     mk(20'h00106, 0, 0, 0, 20'h00105, 0, 1, 1));

        // Reset asserted in the middle of a PUSH cycle.
        cyc(0, 1, 0, 20'h000AB, mk(20'h000AB, 1, 1, 0, 20'h00107, 1, 1, 1));
        CALL = 1'b0;
        @(negedge CLK2);
        #1;
        RST_N = 1'b0;
        #1;
        push_exp(mk(20'h00100, 0, 0, 0, 20'h0, 0, 0, 0));
        @(negedge CLK2);
        #1;
        RST_N = 1'b1;
        cyc(1, 0, 0, 20'h0,     mk(20'h00101, 0, 0, 0, 20'h0, 0, 0, 0));
        STEP = 1'b0; CALL = 1'b0; RET = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK2);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected snapshots left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
